// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: execute-stage controller for the shared multi-cycle
// multiply/divide unit. It detects mul/div in D/X and latches the operands
// and destination. It pulses start and freezes the front of the pipeline
// while the unit works, then overrides X/M with the result or with an
// rstatus exception write. A watchdog bounds every operation.
module multdiv_sequencer #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6,
   parameter int MUL_EXC = 4,
   parameter int DIV_EXC = 5,
   parameter int TMO_EXC = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       dx_insn,
   input  logic [31:0]       dx_A,
   input  logic [31:0]       dx_B,
   input  logic [31:0]       md_result,
   input  logic              md_exception,
   input  logic              md_resultRDY,
   output logic              md_ctrlMULT,
   output logic              md_ctrlDIV,
   output logic [31:0]       md_opA,
   output logic [31:0]       md_opB,
   output logic              stall,
   output logic              xm_override,
   output logic [31:0]       xm_result,
   output logic [4:0]        xm_rd,
   output logic [CNT_W-1:0]  busy_cycles
);

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   // Exceptions are reported through rstatus.
   localparam logic [4:0] RSTATUS = 5'd30;

   state_t            state_reg, state_next;
   logic [31:0]       op_a_reg, op_b_reg;
   logic [4:0]        rd_reg;
   logic              is_div_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [31:0]       res_reg;
   logic [4:0]        res_rd_reg;
   logic              md_hit;
   logic              timeout_hit;
   logic              unused_bits;

   // R-type opcode with ALU op mul (00110) or div (00111).
   assign md_hit = (dx_insn[31:27] == 5'b00000) &&
                   ((dx_insn[6:2] == 5'b00110) || (dx_insn[6:2] == 5'b00111));

   // Watchdog: the last permitted BUSY cycle is the one where the count
   // still reads TIMEOUT-1 (it increments on that same edge).
   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

   // Operand and rs/rt fields are not needed for decode.
   assign unused_bits = ^{dx_insn[21:7], dx_insn[1:0]};

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and control outputs.
   always_comb begin
      state_next  = state_reg;
      stall       = 1'b0;
      md_ctrlMULT = 1'b0;
      md_ctrlDIV  = 1'b0;
      xm_override = 1'b0;
      xm_result   = 32'd0;
      xm_rd       = 5'd0;
      case (state_reg)
         IDLE: begin
            if (md_hit) begin
               stall      = 1'b1;
               state_next = START;
            end
         end
         START: begin
            stall       = 1'b1;
            md_ctrlMULT = !is_div_reg;
            md_ctrlDIV  = is_div_reg;
            state_next  = BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (md_resultRDY || timeout_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // stall stays low so the mul/div leaves D/X at the end of DONE.
            xm_override = 1'b1;
            xm_result   = res_reg;
            xm_rd       = res_rd_reg;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand/destination latch, busy counter and completion capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_a_reg   <= 32'd0;
         op_b_reg   <= 32'd0;
         rd_reg     <= 5'd0;
         is_div_reg <= 1'b0;
         cnt_reg    <= '0;
         res_reg    <= 32'd0;
         res_rd_reg <= 5'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (md_hit) begin
                  op_a_reg   <= dx_A;
                  op_b_reg   <= dx_B;
                  rd_reg     <= dx_insn[26:22];
                  is_div_reg <= dx_insn[2];
                  cnt_reg    <= '0;
               end
            end
            BUSY: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (md_resultRDY) begin
                  if (md_exception) begin
                     res_reg    <= is_div_reg ? 32'(DIV_EXC) : 32'(MUL_EXC);
                     res_rd_reg <= RSTATUS;
                  end else begin
                     res_reg    <= md_result;
                     res_rd_reg <= rd_reg;
                  end
               end else if (timeout_hit) begin
                  res_reg    <= 32'(TMO_EXC);
                  res_rd_reg <= RSTATUS;
               end
            end
            default: ;
         endcase
      end
   end

   assign md_opA      = op_a_reg;
   assign md_opB      = op_b_reg;
   assign busy_cycles = cnt_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Testbench for multdiv_sequencer: table of operations applied in a loop,
// plus hand-written back-to-back and mid-operation reset sequences. Expected
// X/M overrides go into a scoreboard queue when an op is issued and are
// compared when the DUT raises xm_override.
module tb_multdiv_sequencer;

   localparam int TIMEOUT = 40;
   localparam int CNT_W   = 6;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [31:0]       dx_insn = 32'd0;
   logic [31:0]       dx_A = 32'd0;
   logic [31:0]       dx_B = 32'd0;
   logic [31:0]       md_result = 32'd0;
   logic              md_exception = 1'b0;
   logic              md_resultRDY = 1'b0;
   logic              md_ctrlMULT, md_ctrlDIV;
   logic [31:0]       md_opA, md_opB;
   logic              stall, xm_override;
   logic [31:0]       xm_result;
   logic [4:0]        xm_rd;
   logic [CNT_W-1:0]  busy_cycles;

   multdiv_sequencer #(
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .MUL_EXC(4), .DIV_EXC(5), .TMO_EXC(7)
   ) dut (
      .clock(clock), .reset(reset),
      .dx_insn(dx_insn), .dx_A(dx_A), .dx_B(dx_B),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .md_ctrlMULT(md_ctrlMULT), .md_ctrlDIV(md_ctrlDIV),
      .md_opA(md_opA), .md_opB(md_opB),
      .stall(stall), .xm_override(xm_override),
      .xm_result(xm_result), .xm_rd(xm_rd), .busy_cycles(busy_cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] a;
      logic [31:0] b;
      int          delay;      // RDY cycle = pulse cycle + delay; 0 = only during START
      logic [31:0] res;
      logic        exc;
      bit          hit;
      logic [31:0] exp_result;
      logic [4:0]  exp_rd;
      int          exp_busy;
   } vec_t;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      int          busy;
   } sb_t;

   sb_t  sb[$];
   sb_t  mon_e;
   vec_t vecs[10];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] aluop);
      return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
   endfunction

   function automatic vec_t mkv(input logic [31:0] insn, input logic [31:0] a,
                                input logic [31:0] b, input int delay,
                                input logic [31:0] res, input logic exc, input bit hit,
                                input logic [31:0] er, input logic [4:0] erd, input int eb);
      vec_t v;
      v.insn = insn; v.a = a; v.b = b; v.delay = delay; v.res = res; v.exc = exc;
      v.hit = hit; v.exp_result = er; v.exp_rd = erd; v.exp_busy = eb;
      return v;
   endfunction

   // Scoreboard monitor: every override must match the oldest expected entry.
   always @(negedge clock) begin
      if (xm_override === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_override: actual xm_rd=%0d xm_result=%0d required no override",
                     xm_rd, xm_result);
         end else begin
            mon_e = sb.pop_front();
            check("xm_result", {32'd0, xm_result}, {32'd0, mon_e.result});
            check("xm_rd", {59'd0, xm_rd}, {59'd0, mon_e.rd});
            check("busy_cycles", {58'd0, busy_cycles}, 64'(mon_e.busy));
            check("stall_in_done", {63'd0, stall}, 64'd0);
         end
      end
   end

   // Drive one instruction in D/X (held while stalled) and track the op to DONE.
   task automatic run_op(input int idx, input vec_t v, input bit chg);
      int cyc, done_cyc, stall_cnt, mul_cnt, div_cnt, pulse_cyc, exp_done, limit;
      bit op_stable;
      sb_t e;
      cyc = 0; done_cyc = -1; stall_cnt = 0; mul_cnt = 0; div_cnt = 0; pulse_cyc = -1;
      op_stable = 1'b1;
      if (v.hit) begin
         e.result = v.exp_result; e.rd = v.exp_rd; e.busy = v.exp_busy;
         sb.push_back(e);
      end
      exp_done = !v.hit ? -1 : ((v.delay == 0) ? TIMEOUT + 2 : v.delay + 2);
      limit    = v.hit ? 100 : 4;
      while (done_cyc < 0 && cyc < limit) begin
         @(posedge clock);
         #1;
         dx_insn = v.insn;
         if (chg && cyc >= 1) begin
            dx_A = $urandom;
            dx_B = $urandom;
         end else begin
            dx_A = v.a;
            dx_B = v.b;
         end
         md_resultRDY = v.hit && (cyc == 1 + v.delay);
         md_result    = md_resultRDY ? v.res : $urandom;
         md_exception = md_resultRDY ? v.exc : 1'b0;
         @(negedge clock);
         if (stall) stall_cnt++;
         if (md_ctrlMULT) begin mul_cnt++; pulse_cyc = cyc; end
         if (md_ctrlDIV) begin div_cnt++; pulse_cyc = cyc; end
         if (v.hit && cyc >= 1 && (md_opA !== v.a || md_opB !== v.b)) op_stable = 1'b0;
         if (xm_override) done_cyc = cyc;
         cyc++;
      end
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
      if (v.hit) begin
         check("done_cycle", 64'(done_cyc), 64'(exp_done));
         check("stall_cycles", 64'(stall_cnt), 64'(exp_done));
         check("mult_pulses", 64'(mul_cnt), v.insn[2] ? 64'd0 : 64'd1);
         check("div_pulses", 64'(div_cnt), v.insn[2] ? 64'd1 : 64'd0);
         check("pulse_cycle", 64'(pulse_cyc), 64'd1);
         check("operands_stable", {63'd0, op_stable}, 64'd1);
      end else begin
         check("nonhit_stall", 64'(stall_cnt), 64'd0);
         check("nonhit_pulses", 64'(mul_cnt + div_cnt), 64'd0);
         check("nonhit_override", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      end
      $display("[TB] op %0d insn=%h hit=%0d done_cyc=%0d stall_cycles=%0d", idx, v.insn, v.hit,
               done_cyc, stall_cnt);
   endtask

   // Start a mul, reset during BUSY cycle 5, then offer a stray RDY.
   task automatic reset_mid_op();
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clock);
         #1;
         dx_insn      = (cyc <= 6) ? mk_r(5'd4, 5'b00110) : 32'd0;
         dx_A         = 32'd11;
         dx_B         = 32'd13;
         reset        = (cyc == 6);
         md_resultRDY = (cyc >= 7);
         md_exception = (cyc >= 7);
         md_result    = 32'hDEAD_BEEF;
         @(negedge clock);
         if (cyc == 6) begin
            check("rst_busy_before", {58'd0, busy_cycles}, 64'd4);
            check("rst_stall_before", {63'd0, stall}, 64'd1);
         end
         if (cyc == 7) begin
            check("rst_stall", {63'd0, stall}, 64'd0);
            check("rst_pulses", {62'd0, md_ctrlMULT, md_ctrlDIV}, 64'd0);
            check("rst_xm_result", {32'd0, xm_result}, 64'd0);
            check("rst_xm_rd", {59'd0, xm_rd}, 64'd0);
            check("rst_opA", {32'd0, md_opA}, 64'd0);
            check("rst_opB", {32'd0, md_opB}, 64'd0);
            check("rst_busy", {58'd0, busy_cycles}, 64'd0);
         end
         if (cyc >= 7) check("rst_no_override", {63'd0, xm_override}, 64'd0);
      end
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
      $display("[TB] reset mid-op sequence complete");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual simulation still running required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      vecs[0] = mkv(mk_r(5'd5, 5'b00110), 32'd3, 32'd4, 17, 32'd12, 1'b0, 1'b1, 32'd12, 5'd5, 17);
      vecs[1] = mkv(mk_r(5'd7, 5'b00111), 32'd9, 32'd0, 6, 32'd0, 1'b1, 1'b1, 32'd5, 5'd30, 6);
      vecs[2] = mkv(mk_r(5'd9, 5'b00110), 32'h7FFF_FFFF, 32'd6, 3, 32'd0, 1'b1, 1'b1, 32'd4, 5'd30, 3);
      vecs[3] = mkv(mk_r(5'd3, 5'b00111), 32'd100, 32'd7, 1, 32'd14, 1'b0, 1'b1, 32'd14, 5'd3, 1);
      vecs[4] = mkv(mk_r(5'd0, 5'b00110), 32'd5, 32'd11, 2, 32'd55, 1'b0, 1'b1, 32'd55, 5'd0, 2);
      vecs[5] = mkv(mk_r(5'd12, 5'b00110), 32'd2, 32'd2, 0, 32'd4, 1'b0, 1'b1, 32'd7, 5'd30, TIMEOUT);
      vecs[6] = mkv(mk_r(5'd6, 5'b00000), 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0, 0);
      vecs[7] = mkv({5'b00111, 5'd3, 5'd1, 12'd0, 5'b00110, 2'b00}, 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b0,
                    32'd0, 5'd0, 0);
      vecs[8] = mkv({5'b10110, 20'd0, 5'b00111, 2'b00}, 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b0,
                    32'd0, 5'd0, 0);
      vecs[9] = mkv(mk_r(5'd8, 5'b00101), 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0, 0);

      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_stall", {63'd0, stall}, 64'd0);
      check("reset_override", {63'd0, xm_override}, 64'd0);
      check("reset_busy", {58'd0, busy_cycles}, 64'd0);
      check("reset_opA", {32'd0, md_opA}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(i, vecs[i], 1'b0);
      end

      // Back-to-back muls; the second sees bypass inputs change mid-op.
      run_op(10, mkv(mk_r(5'd1, 5'b00110), 32'd6, 32'd7, 4, 32'd42, 1'b0, 1'b1, 32'd42, 5'd1, 4),
             1'b0);
      run_op(11, mkv(mk_r(5'd2, 5'b00110), 32'd8, 32'd9, 5, 32'd72, 1'b0, 1'b1, 32'd72, 5'd2, 5),
             1'b1);

      reset_mid_op();

      // Normal operation after the reset.
      run_op(12, mkv(mk_r(5'd15, 5'b00111), 32'd50, 32'd5, 3, 32'd10, 1'b0, 1'b1, 32'd10, 5'd15, 3),
             1'b0);

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Execute-stage controller that runs the shared multi-cycle multiply/divide unit for the 5-stage pipeline. It detects `mul`/`div` in D/X, latches operands and destination, issues a one-cycle start pulse, and freezes F, D and X until the unit reports ready. It then presents the result, or an rstatus exception write, as an override into X/M. It also bounds every operation with a watchdog and counts busy cycles.

## Interface
Parameters:
- `TIMEOUT`, 40: maximum BUSY cycles before forced completion.
- `CNT_W`, 6: width of the busy-cycle counter; must hold `TIMEOUT`.
- `MUL_EXC`, 4: rstatus code for multiply overflow.
- `DIV_EXC`, 5: rstatus code for divide by zero.
- `TMO_EXC`, 7: rstatus code for a watchdog timeout.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `dx_insn`  in  32  instruction currently in D/X.
- `dx_A`, `dx_B`  in  32  post-bypass operands for the D/X instruction.
- `md_result`  in  32  multdiv result.
- `md_exception`  in  1  multdiv exception flag, valid with ready.
- `md_resultRDY`  in  1  multdiv ready.
- `md_ctrlMULT`, `md_ctrlDIV`  out  1  one-cycle start pulses.
- `md_opA`, `md_opB`  out  32  registered operands, held stable from start until return to IDLE.
- `stall`  out  1  freeze PC, F/D and D/X.
- `xm_override`  out  1  X/M must take `xm_result`/`xm_rd` instead of the ALU path.
- `xm_result`  out  32  value to write.
- `xm_rd`  out  5  destination register.
- `busy_cycles`  out  CNT_W  BUSY cycles of the last or current op.

## Operation
- Detection is `md_hit = (dx_insn[31:27]==00000) & (dx_insn[6:2]==00110 | dx_insn[6:2]==00111)`, i.e. R-type `mul`/`div`. It is evaluated only in IDLE.
- States are IDLE, START, BUSY and DONE.
- IDLE → START on `md_hit`. On that edge:
  - latch `dx_A`/`dx_B` into `md_opA`/`md_opB`;
  - latch `rd = dx_insn[26:22]`;
  - latch `is_div = dx_insn[2]`.
- START → BUSY, unconditionally. The start pulse is on `md_ctrlMULT` when `!is_div`, otherwise on `md_ctrlDIV`. It is high during START only. `md_resultRDY` is ignored in START.
- BUSY:
  - `busy_cycles` increments each cycle; it is cleared on entry to START.
  - On `md_resultRDY`: capture `md_result`/`md_exception`, then → DONE.
  - Else if `busy_cycles == TIMEOUT-1`: force a timeout, then → DONE.
- DONE → IDLE, unconditionally. During DONE:
  - `xm_override = 1`.
  - Normal completion: `xm_result` = captured result, `xm_rd` = latched rd.
  - `md_exception` captured: `xm_result` = `is_div ? DIV_EXC : MUL_EXC`, `xm_rd` = 30.
  - Timeout: `xm_result` = `TMO_EXC`, `xm_rd` = 30.
- `stall = (IDLE & md_hit) | START | BUSY`. It is combinational and low in DONE, so the mul/div advances into X/M at the end of DONE.
- No re-detection happens in DONE. Back-to-back mul/div ops each take a full IDLE→DONE cycle.
- `rd == 0` is still written through the override path; the register file discards it. Exceptions always target r30.
- Reset, including mid-operation: state = IDLE. All outputs are 0: `stall` (unless `md_hit` drives it in IDLE), pulses, `xm_*`, `md_op*`, `busy_cycles`. An operation in flight is abandoned and a later RDY is ignored.

## Timing
- Detect cycle D (IDLE, `stall=1`) → START at D+1 (pulse) → BUSY from D+2.
- RDY first seen in BUSY at cycle R → DONE at R+1 (`xm_override=1`, `stall=0`) → IDLE at R+2.
- Total stall cycles equal R−D+1.
- RDY arriving in START is dropped. The bench must never see early completion.
- A timeout fires in BUSY cycle `TIMEOUT`, giving DONE at D+2+`TIMEOUT`.
- `md_opA`/`md_opB` do not change from START through DONE, even while bypass inputs change.
- `busy_cycles` holds its value in DONE and IDLE until the next START.

## Test plan
- `mul r5,r1,r2` with A=3, B=4, RDY 17 cycles after the pulse, exc=0 → one `md_ctrlMULT` pulse; `stall` high 19 cycles; DONE shows `xm_override=1`, `xm_result=12`, `xm_rd=5`, `busy_cycles=17`.
- `div r7,r1,r2` with B=0, RDY+exc → `md_ctrlDIV` pulse; DONE shows `xm_rd=30`, `xm_result=5`.
- Two consecutive `mul`s, the second with bypassed operands changing mid-op → first result correct; second detected in the IDLE after DONE; `md_opA` stable during each op.
- RDY asserted during START and never again → no completion at START; timeout gives `xm_rd=30`, `xm_result=7`, `busy_cycles=TIMEOUT`.
- `reset` in BUSY cycle 5, then stray RDY → all outputs 0; no `xm_override` is produced.
- `add`/`sw`/`bex` in D/X → `stall=0`, no pulses, `xm_override=0`.
